// File: rtl/fetch_pc_unit_pkg.sv
// Shared ISA constants and fetch-unit FSM encoding for the single-cycle CPU.
package fetch_pc_unit_pkg;
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam int T_W   = 27;
    localparam int N_W   = 17;
    localparam int REG_W = 32;

    localparam logic [4:0] REG_RSTATUS = 5'd30;
    localparam logic [4:0] REG_RA      = 5'd31;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/fetch_pc_unit_if.sv
// Decoder/ALU-to-fetch bundle: flow-control strobes in, PC and status out.
interface fetch_pc_unit_if #(
    parameter int PC_W  = 12,
    parameter int CNT_W = 32
);
    import fetch_pc_unit_pkg::*;

    logic                    stall;
    logic                    Jp;
    logic                    jal;
    logic                    jr;
    logic                    bne;
    logic                    blt;
    logic                    bex;
    logic [T_W-1:0]          target;
    logic signed [N_W-1:0]   imm;
    logic [REG_W-1:0]        rd_val;
    logic                    neq;
    logic                    lt;
    logic                    rstatus_nz;
    logic [PC_W-1:0]         pc;
    logic [REG_W-1:0]        pc_plus1;
    logic                    instr_valid;
    logic                    redirect;
    logic [CNT_W-1:0]        retired;

    modport master (
        output stall, Jp, jal, jr, bne, blt, bex, target, imm, rd_val, neq, lt, rstatus_nz,
        input  pc, pc_plus1, instr_valid, redirect, retired
    );

    modport slave (
        input  stall, Jp, jal, jr, bne, blt, bex, target, imm, rd_val, neq, lt, rstatus_nz,
        output pc, pc_plus1, instr_valid, redirect, retired
    );
endinterface

// File: rtl/fetch_pc_unit_pc_target_adder.sv
// Sequential and PC-relative branch targets; both wrap modulo 2**PC_W.
module pc_target_adder
    import fetch_pc_unit_pkg::*;
#(
    parameter int PC_W = 12
) (
    input  logic [PC_W-1:0]        pc,
    input  logic signed [N_W-1:0]  imm,
    output logic [PC_W-1:0]        pc_inc,
    output logic [PC_W-1:0]        branch_pc
);
    // The size cast sign-extends or truncates imm to PC_W; either way the sum is correct mod 2**PC_W.
    assign pc_inc    = pc + PC_W'(1);
    assign branch_pc = pc_inc + PC_W'(imm);
endmodule

// File: rtl/fetch_pc_unit.sv
// Program-counter sequencer: boot bubble, stall hold, prioritised next-PC select, retire counter.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int PC_W  = 12,
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    fetch_pc_unit_if.slave   bus
);
    fetch_state_t      state;
    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   branch_pc;
    logic [PC_W-1:0]   next_pc;
    logic              instr_valid_q;
    logic [CNT_W-1:0]  retired_q;
    logic              active;
    logic              taken;
    logic              unused_bits;

    // An instruction advances only outside BOOT with no multdiv stall pending.
    assign active = (state != ST_BOOT) && !bus.stall;

    pc_target_adder #(.PC_W(PC_W)) u_adder (
        .pc        (pc_q),
        .imm       (bus.imm),
        .pc_inc    (pc_inc),
        .branch_pc (branch_pc)
    );

    always_comb begin
        next_pc = pc_inc;
        taken   = 1'b0;
        if (bus.jr) begin
            next_pc = bus.rd_val[PC_W-1:0];
            taken   = 1'b1;
        end else if (bus.Jp) begin
            next_pc = bus.target[PC_W-1:0];
            taken   = 1'b1;
        end else if (bus.bex && bus.rstatus_nz) begin
            next_pc = bus.target[PC_W-1:0];
            taken   = 1'b1;
        end else if (bus.bne && bus.neq) begin
            next_pc = branch_pc;
            taken   = 1'b1;
        end else if (bus.blt && bus.lt) begin
            next_pc = branch_pc;
            taken   = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_BOOT;
            pc_q          <= '0;
            instr_valid_q <= 1'b0;
            retired_q     <= '0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state         <= bus.stall ? ST_STALL : ST_RUN;
                    instr_valid_q <= 1'b1;
                end
                ST_RUN, ST_STALL: state <= bus.stall ? ST_STALL : ST_RUN;
                default:          state <= ST_BOOT;
            endcase
            if (active) begin
                pc_q      <= next_pc;
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus1    = REG_W'(pc_inc);
    assign bus.instr_valid = instr_valid_q;
    assign bus.redirect    = active && taken;
    assign bus.retired     = retired_q;

    // jal only matters to the regfile; target/rd_val bits above PC_W are don't-care here.
    assign unused_bits = ^{bus.jal, bus.target[T_W-1:PC_W], bus.rd_val[REG_W-1:PC_W]};
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed and randomized bench for fetch_pc_unit against an arithmetic next-PC model.
module tb_fetch_pc_unit;
    localparam int PC_W  = 12;
    localparam int CNT_W = 32;
    localparam int PCM   = 1 << PC_W;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    int    m_pc;
    longint m_ret;
    bit    m_boot;

    fetch_pc_unit_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    fetch_pc_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.stall      = 1'b0;
        bus.Jp         = 1'b0;
        bus.jal        = 1'b0;
        bus.jr         = 1'b0;
        bus.bne        = 1'b0;
        bus.blt        = 1'b0;
        bus.bex        = 1'b0;
        bus.target     = '0;
        bus.imm        = '0;
        bus.rd_val     = '0;
        bus.neq        = 1'b0;
        bus.lt         = 1'b0;
        bus.rstatus_nz = 1'b0;
    endtask

    // Next PC straight from the priority rules, using integer arithmetic modulo 2**PC_W.
    task automatic model_next(output int np, output bit tk);
        int rel;
        rel = ((m_pc + 1 + int'(bus.imm)) % PCM + PCM) % PCM;
        tk  = 1'b1;
        if (bus.jr)                          np = int'(bus.rd_val & 32'hFFF);
        else if (bus.Jp)                     np = int'(bus.target & 27'hFFF);
        else if (bus.bex && bus.rstatus_nz)  np = int'(bus.target & 27'hFFF);
        else if (bus.bne && bus.neq)         np = rel;
        else if (bus.blt && bus.lt)          np = rel;
        else begin
            np = (m_pc + 1) % PCM;
            tk = 1'b0;
        end
    endtask

    task automatic cycle(input string tag);
        int np;
        bit tk;
        bit act;
        #1;
        model_next(np, tk);
        act = !m_boot && !bus.stall;
        check($sformatf("%s redirect", tag), bus.redirect, act && tk);
        check($sformatf("%s pc_plus1", tag), bus.pc_plus1, (m_pc + 1) % PCM);
        @(posedge clock);
        #1;
        if (m_boot) m_boot = 1'b0;
        else if (act) begin
            m_pc  = np;
            m_ret = (m_ret + 1) & 64'hFFFF_FFFF;
        end
        check($sformatf("%s pc", tag), bus.pc, m_pc);
        check($sformatf("%s instr_valid", tag), bus.instr_valid, !m_boot);
        check($sformatf("%s retired", tag), bus.retired, m_ret);
    endtask

    task automatic goto(input int n);
        clear_inputs();
        bus.jr     = 1'b1;
        bus.rd_val = 32'(n);
        cycle("goto");
        clear_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clock  = 1'b0;
        reset  = 1'b1;
        clear_inputs();
        m_pc   = 0;
        m_ret  = 0;
        m_boot = 1'b1;

        #1;
        check("reset pc", bus.pc, 0);
        check("reset instr_valid", bus.instr_valid, 0);
        check("reset retired", bus.retired, 0);
        check("reset redirect", bus.redirect, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("held reset pc", bus.pc, 0);

        // Boot bubble then sequential fetch
        repeat (4) cycle("seq");
        check("seq final pc", bus.pc, 3);
        check("seq final retired", bus.retired, 3);

        goto(5);
        bus.bne = 1'b1; bus.neq = 1'b1; bus.imm = 17'h1FFFD;
        cycle("bne taken");
        check("bne taken pc", bus.pc, 3);
        goto(5);
        bus.bne = 1'b1; bus.neq = 1'b0; bus.imm = 17'h1FFFD;
        cycle("bne untaken");
        check("bne untaken pc", bus.pc, 6);

        goto(10);
        bus.jr = 1'b1; bus.Jp = 1'b1; bus.rd_val = 32'd40; bus.target = 27'd99;
        cycle("jr priority");
        check("jr priority pc", bus.pc, 40);
        goto(10);
        bus.bex = 1'b1; bus.rstatus_nz = 1'b0; bus.target = 27'd99;
        cycle("bex untaken");
        check("bex untaken pc", bus.pc, 11);

        goto(7);
        bus.blt = 1'b1; bus.lt = 1'b1; bus.imm = 17'd4; bus.stall = 1'b1;
        repeat (3) cycle("blt stalled");
        check("stall hold pc", bus.pc, 7);
        bus.stall = 1'b0;
        cycle("blt resume");
        check("blt resume pc", bus.pc, 12);

        goto(12'hFFF);
        cycle("wrap");
        check("wrap pc", bus.pc, 0);
        goto(12'hFFF);
        bus.Jp = 1'b1; bus.jal = 1'b1; bus.target = 27'h7FFFFFF;
        cycle("jal truncate");
        check("jal truncate pc", bus.pc, 12'hFFF);

        // Asynchronous reset in the middle of a stall
        goto(20);
        bus.stall = 1'b1;
        cycle("pre-reset stall");
        #2;
        reset = 1'b1;
        #1;
        check("async reset pc", bus.pc, 0);
        check("async reset retired", bus.retired, 0);
        check("async reset instr_valid", bus.instr_valid, 0);
        m_pc   = 0;
        m_ret  = 0;
        m_boot = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        clear_inputs();
        cycle("reboot");
        cycle("reboot run");
        check("reboot pc", bus.pc, 1);

        repeat (400) begin
            bus.stall      = ($urandom_range(0, 4) == 0);
            bus.jr         = ($urandom_range(0, 9) == 0);
            bus.Jp         = ($urandom_range(0, 9) == 0);
            bus.jal        = bus.Jp && $urandom_range(0, 1) == 1;
            bus.bex        = ($urandom_range(0, 5) == 0);
            bus.bne        = ($urandom_range(0, 4) == 0);
            bus.blt        = ($urandom_range(0, 4) == 0);
            bus.target     = 27'($urandom);
            bus.imm        = 17'($urandom);
            bus.rd_val     = $urandom;
            bus.neq        = 1'($urandom);
            bus.lt         = 1'($urandom);
            bus.rstatus_nz = 1'($urandom);
            cycle("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
